// File: rtl/chip_checker_platorm_dbg_mem_ctl_pkg.sv
// Shared constants for the debug-memory controller: FSM encoding, default
// parameters, jdo field positions and the read-timeout fill pattern.
package chip_checker_platorm_dbg_mem_ctl_pkg;

    localparam int unsigned ADDR_W_DEF  = 10;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned JDO_W       = 38;

    // jdo field positions
    localparam int unsigned ADDR_HI    = 33;
    localparam int unsigned ADDR_LO    = 24;
    localparam int unsigned LDADDR_BIT = 34;
    localparam int unsigned RD_BIT     = 35;
    localparam int unsigned CLRERR_BIT = 36;
    localparam int unsigned WDATA_HI   = 34;
    localparam int unsigned WDATA_LO   = 3;

    // Value returned in MonDReg when a read never gets a response
    localparam logic [31:0] DEAD_DEAD = 32'hDEAD_DEAD;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RD_REQ  = 2'd1;
    localparam state_t ST_RD_WAIT = 2'd2;
    localparam state_t ST_WR_REQ  = 2'd3;

endpackage

// File: rtl/chip_checker_platorm_dbg_mem_ctl_if.sv
// Avalon-MM style memory bus between the debug controller and the memory.
interface chip_checker_platorm_dbg_mem_ctl_if
    import chip_checker_platorm_dbg_mem_ctl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_waitrequest;
    logic [31:0]       mem_readdata;
    logic              mem_readdatavalid;

    modport master (
        output mem_address,
        output mem_read,
        output mem_write,
        output mem_writedata,
        input  mem_waitrequest,
        input  mem_readdata,
        input  mem_readdatavalid
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        input  mem_write,
        input  mem_writedata,
        output mem_waitrequest,
        output mem_readdata,
        output mem_readdatavalid
    );

endinterface

// File: rtl/chip_checker_platorm_dbg_mem_timeout.sv
// Read-response timeout counter: cleared by start, counts while tick_en is
// high, and flags expired once the count equals TIMEOUT.
module chip_checker_platorm_dbg_mem_timeout
    import chip_checker_platorm_dbg_mem_ctl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic tick_en,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CntW-1:0] cnt_q;

    assign expired = (cnt_q == CntW'(TIMEOUT));

    // Count stops at TIMEOUT so it can never wrap back below the limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (tick_en && !expired) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/chip_checker_platorm_dbg_mem_ctl.sv
// Debug memory controller: turns JTAG-side command strobes into single
// Avalon-MM reads/writes, returns read data in MonDReg and tracks
// completion (monitor_ready) and a sticky error flag (monitor_error).
module chip_checker_platorm_dbg_mem_ctl
    import chip_checker_platorm_dbg_mem_ctl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [JDO_W-1:0]                     jdo,
    input  logic                                 take_action_ocimem_a,
    input  logic                                 take_action_ocimem_b,
    input  logic                                 take_no_action_ocimem_a,
    chip_checker_platorm_dbg_mem_ctl_if.master   mem,
    output logic [31:0]                          MonDReg,
    output logic                                 monitor_ready,
    output logic                                 monitor_error
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mond_q, mond_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;

    logic is_idle, any_strobe, acc_a, acc_b, acc_na, drop;
    logic err_set, err_clr;
    logic to_start, to_tick, to_expired;

    // jdo[37] and jdo[2:0] carry nothing for this block
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37], jdo[2:0]};

    assign mem.mem_address   = addr_q;
    assign mem.mem_read      = rd_q;
    assign mem.mem_write     = wr_q;
    assign mem.mem_writedata = wdata_q;
    assign MonDReg           = mond_q;
    assign monitor_ready     = ready_q;
    assign monitor_error     = error_q;

    // Strobe arbitration: a beats b beats no_action, and only idle accepts
    always_comb begin
        is_idle    = (state_q == ST_IDLE);
        any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        acc_a      = is_idle && take_action_ocimem_a;
        acc_b      = is_idle && take_action_ocimem_b && !take_action_ocimem_a;
        acc_na     = is_idle && take_no_action_ocimem_a && !take_action_ocimem_a
                     && !take_action_ocimem_b;
        drop       = any_strobe && (!is_idle
                     || (take_action_ocimem_a && take_action_ocimem_b)
                     || (take_action_ocimem_a && take_no_action_ocimem_a)
                     || (take_action_ocimem_b && take_no_action_ocimem_a));
    end

    assign to_start = (state_q == ST_RD_REQ) && rd_q && !mem.mem_waitrequest;
    assign to_tick  = (state_q == ST_RD_WAIT);

    chip_checker_platorm_dbg_mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (to_start),
        .tick_en (to_tick),
        .expired (to_expired)
    );

    // Next-state: command decode, bus handshake and completion bookkeeping
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        mond_d  = mond_q;
        ready_d = ready_q;
        err_set = drop;
        err_clr = acc_a && jdo[CLRERR_BIT];

        case (state_q)
            ST_IDLE: begin
                if (acc_a) begin
                    if (jdo[LDADDR_BIT]) begin
                        addr_d = ADDR_W'(jdo[ADDR_HI:ADDR_LO]);
                    end
                    if (jdo[RD_BIT]) begin
                        state_d = ST_RD_REQ;
                        rd_d    = 1'b1;
                        ready_d = 1'b0;
                    end
                end else if (acc_b) begin
                    state_d = ST_WR_REQ;
                    wr_d    = 1'b1;
                    wdata_d = jdo[WDATA_HI:WDATA_LO];
                    ready_d = 1'b0;
                end else if (acc_na) begin
                    state_d = ST_RD_REQ;
                    rd_d    = 1'b1;
                    ready_d = 1'b0;
                end
            end
            ST_RD_REQ: begin
                if (rd_q && !mem.mem_waitrequest) begin
                    state_d = ST_RD_WAIT;
                    rd_d    = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                // A response on the expiry cycle still counts as a good read
                if (mem.mem_readdatavalid) begin
                    state_d = ST_IDLE;
                    mond_d  = mem.mem_readdata;
                    ready_d = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                end else if (to_expired) begin
                    state_d = ST_IDLE;
                    mond_d  = DEAD_DEAD;
                    ready_d = 1'b1;
                    err_set = 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (wr_q && !mem.mem_waitrequest) begin
                    state_d = ST_IDLE;
                    wr_d    = 1'b0;
                    ready_d = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase

        // Set wins over a clear on the same edge
        error_d = (error_q && !err_clr) || err_set;
    end

    // State registers with asynchronous reset to the idle/ready condition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            mond_q  <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            mond_q  <= mond_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_chip_checker_platorm_dbg_mem_ctl.sv
// Bench for the debug memory controller: directed scenarios plus a random
// transaction mix, checked against a transaction-level model.
module tb_chip_checker_platorm_dbg_mem_ctl;

    localparam int unsigned AW = 10;
    localparam int          TO = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        sa = 1'b0;
    logic        sb = 1'b0;
    logic        sn = 1'b0;
    logic [31:0] mond;
    logic        rdy;
    logic        err;

    chip_checker_platorm_dbg_mem_ctl_if #(.ADDR_W(AW)) bus ();

    chip_checker_platorm_dbg_mem_ctl #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (sa),
        .take_action_ocimem_b    (sb),
        .take_no_action_ocimem_a (sn),
        .mem                     (bus.master),
        .MonDReg                 (mond),
        .monitor_ready           (rdy),
        .monitor_error           (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Slave storage and the model's view of memory
    logic [31:0] smem [1024];
    logic [31:0] rmem [1024];
    logic [9:0]  slv_addr;

    // Transaction-level model
    logic [9:0]  m_addr;
    logic [31:0] m_mond;
    logic        m_rdy;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(input logic clr, input logic rd, input logic ld,
                                          input logic [9:0] a);
        logic [37:0] j;
        j = '0;
        j[36] = clr;
        j[35] = rd;
        j[34] = ld;
        j[33:24] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic strobe(input logic a, input logic b, input logic n, input logic [37:0] j);
        sa = a;
        sb = b;
        sn = n;
        jdo = j;
        step();
        sa = 1'b0;
        sb = 1'b0;
        sn = 1'b0;
        jdo = '0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_mond"}, mond, m_mond);
        chk1({tag, "_rdy"}, rdy, m_rdy);
        chk1({tag, "_err"}, err, m_err);
        chk1({tag, "_rd"}, bus.mem_read, 1'b0);
        chk1({tag, "_wr"}, bus.mem_write, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mond"}, mond, 32'h0);
        chk1({tag, "_rdy"}, rdy, 1'b1);
        chk1({tag, "_err"}, err, 1'b0);
        chk1({tag, "_rd"}, bus.mem_read, 1'b0);
        chk1({tag, "_wr"}, bus.mem_write, 1'b0);
        chk({tag, "_wdata"}, bus.mem_writedata, 32'h0);
        chk({tag, "_addr"}, 32'(bus.mem_address), 32'h0);
    endtask

    // Stall the pending request for 'waits' cycles, then let it complete
    task automatic bus_req(input int waits);
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        rd0;
        logic        wr0;
        rd0 = bus.mem_read;
        wr0 = bus.mem_write;
        a0  = bus.mem_address;
        d0  = bus.mem_writedata;
        bus.mem_waitrequest = (waits > 0);
        for (int i = 0; i < waits; i++) begin
            step();
            if (i == waits - 1) bus.mem_waitrequest = 1'b0;
            chk1("req_held", bus.mem_read | bus.mem_write, 1'b1);
            chk1("req_kind", bus.mem_read, rd0);
            chk("addr_stable", 32'(bus.mem_address), 32'(a0));
            if (wr0) chk("wdata_stable", bus.mem_writedata, d0);
        end
        step();
        if (wr0) smem[a0] = d0;
        slv_addr = a0;
        chk1("req_released", bus.mem_read | bus.mem_write, 1'b0);
    endtask

    // Return read data 'lat' cycles after the read handshake
    task automatic bus_resp(input int lat);
        for (int i = 1; i < lat; i++) begin
            bus.mem_readdata = $urandom;
            step();
        end
        bus.mem_readdata = smem[slv_addr];
        bus.mem_readdatavalid = 1'b1;
        step();
        bus.mem_readdatavalid = 1'b0;
        bus.mem_readdata = $urandom;
    endtask

    task automatic do_read(input logic use_a, input logic ld, input logic [9:0] a,
                           input int waits, input int lat);
        if (use_a) strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, ld, a));
        else       strobe(1'b0, 1'b0, 1'b1, '0);
        if (use_a && ld) m_addr = a;
        m_rdy = 1'b0;
        chk1("rd_req", bus.mem_read, 1'b1);
        chk1("rd_nowr", bus.mem_write, 1'b0);
        chk("rd_addr", 32'(bus.mem_address), 32'(m_addr));
        chk1("rd_busy", rdy, m_rdy);
        bus_req(waits);
        bus_resp(lat);
        m_mond = rmem[m_addr];
        m_rdy  = 1'b1;
        m_addr = m_addr + 10'd1;
        check_idle("rd_done");
    endtask

    task automatic do_write(input logic [31:0] d, input int waits);
        strobe(1'b0, 1'b1, 1'b0, jdo_b(d));
        m_rdy = 1'b0;
        chk1("wr_req", bus.mem_write, 1'b1);
        chk1("wr_nord", bus.mem_read, 1'b0);
        chk("wr_addr", 32'(bus.mem_address), 32'(m_addr));
        chk("wr_data", bus.mem_writedata, d);
        chk1("wr_busy", rdy, m_rdy);
        bus_req(waits);
        rmem[m_addr] = d;
        m_rdy  = 1'b1;
        m_addr = m_addr + 10'd1;
        check_idle("wr_done");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int kind;
        bus.mem_waitrequest   = 1'b0;
        bus.mem_readdata      = '0;
        bus.mem_readdatavalid = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            smem[i] = $urandom;
            rmem[i] = smem[i];
        end
        smem[5] = 32'h1234_5678;
        rmem[5] = 32'h1234_5678;
        m_addr = '0;
        m_mond = '0;
        m_rdy  = 1'b1;
        m_err  = 1'b0;

        step();
        step();
        check_reset("rst");
        reset_n = 1'b1;

        // Address + read at 5, data back two cycles after the handshake
        do_read(1'b1, 1'b1, 10'h005, 0, 2);
        chk("ar_data", mond, 32'h1234_5678);

        // Write at 6 with three stall cycles, then read it back
        do_write(32'hCAFE_F00D, 3);
        do_read(1'b1, 1'b1, 10'h006, 1, 1);
        chk("wr_readback", mond, 32'hCAFE_F00D);

        // Address-only load keeps ready set; read at top address wraps to 0
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 1'b1, 10'h3FF));
        m_addr = 10'h3FF;
        check_idle("ld_only");
        do_read(1'b0, 1'b0, '0, 0, 1);
        do_read(1'b0, 1'b0, '0, 2, 3);

        // Read with no response at all
        strobe(1'b0, 1'b0, 1'b1, '0);
        m_rdy = 1'b0;
        chk1("to_req", bus.mem_read, 1'b1);
        bus_req(0);
        n = 0;
        while (rdy !== 1'b1 && n < TO + 50) begin
            step();
            n++;
        end
        chk1("to_window", (n >= TO) && (n <= TO + 2), 1'b1);
        m_mond = 32'hDEAD_DEAD;
        m_rdy  = 1'b1;
        m_err  = 1'b1;
        check_idle("timeout");
        chk("to_mond", mond, 32'hDEAD_DEAD);
        do_read(1'b0, 1'b0, '0, 0, 1);

        // Clear, then a write strobe while a read is outstanding
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 1'b0, '0));
        m_err = 1'b0;
        check_idle("clr1");
        strobe(1'b0, 1'b0, 1'b1, '0);
        m_rdy = 1'b0;
        bus_req(1);
        strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h5555_AAAA));
        m_err = 1'b1;
        chk1("busy_err", err, 1'b1);
        chk1("busy_nowr", bus.mem_write, 1'b0);
        bus_resp(1);
        m_mond = rmem[m_addr];
        m_rdy  = 1'b1;
        m_addr = m_addr + 10'd1;
        check_idle("busy_done");

        // a and b together: only the a read runs
        strobe(1'b1, 1'b1, 1'b0, jdo_a(1'b0, 1'b1, 1'b1, 10'h123));
        m_addr = 10'h123;
        m_rdy  = 1'b0;
        chk1("ab_rd", bus.mem_read, 1'b1);
        chk1("ab_nowr", bus.mem_write, 1'b0);
        chk("ab_addr", 32'(bus.mem_address), 32'(m_addr));
        bus_req(0);
        bus_resp(1);
        m_mond = rmem[m_addr];
        m_rdy  = 1'b1;
        m_addr = m_addr + 10'd1;
        check_idle("ab_done");

        // Clear and set on the same edge keeps the error
        strobe(1'b1, 1'b0, 1'b1, jdo_a(1'b1, 1'b0, 1'b0, '0));
        check_idle("clr_set");
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 1'b0, '0));
        m_err = 1'b0;
        check_idle("clr2");

        // Response outside a read is ignored
        bus.mem_readdata = 32'h0BAD_F00D;
        bus.mem_readdatavalid = 1'b1;
        step();
        bus.mem_readdatavalid = 1'b0;
        check_idle("stray_rv");

        // Random transaction mix
        for (int k = 0; k < 30; k++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0)
                do_read(1'b1, 1'($urandom_range(0, 1)), 10'($urandom),
                        int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
            else if (kind == 1)
                do_read(1'b0, 1'b0, '0, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
            else
                do_write($urandom, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a read, then a stale response
        strobe(1'b0, 1'b0, 1'b1, '0);
        bus_req(0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("rst_mid");
        step();
        reset_n = 1'b1;
        m_addr = '0;
        m_mond = '0;
        m_rdy  = 1'b1;
        m_err  = 1'b0;
        bus.mem_readdata = 32'hBAD0_BAD0;
        bus.mem_readdatavalid = 1'b1;
        step();
        bus.mem_readdatavalid = 1'b0;
        check_idle("stale_rv");
        do_read(1'b0, 1'b0, '0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/chip_checker_platorm_dbg_mem_ctl.md
CHIP_CHECKER_PLATORM_DBG_MEM_CTL -- requirements
Module: chip_checker_platorm_dbg_mem_ctl

Interface
REQ-001 Clock and reset SHALL be one clock `clk` and reset `reset_n`, asynchronous, active-low.
REQ-002 Parameters SHALL be, one per line:
- ADDR_W, 10, word-address width.
- TIMEOUT, 255, read-response timeout in clk cycles.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  system clock.
- reset_n  in  1  async active-low reset.
- jdo  in  38  debug command/data word from the JTAG sysclk stage.
- take_action_ocimem_a  in  1  1-cycle strobe: address/read command.
- take_action_ocimem_b  in  1  1-cycle strobe: write command.
- take_no_action_ocimem_a  in  1  1-cycle strobe: read at current address.
- mem_waitrequest  in  1  Avalon-MM slave stall.
- mem_readdata  in  32  Avalon-MM read data.
- mem_readdatavalid  in  1  Avalon-MM read response.
- mem_address  out  ADDR_W  word address.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_writedata  out  32  write data.
- MonDReg  out  32  monitor data register, returned to the JTAG tck stage.
- monitor_ready  out  1  high when the last command has completed.
- monitor_error  out  1  sticky error flag.

Function
REQ-004 Command decode SHALL be as follows:
- take_action_ocimem_a with jdo[34]=1 loads addr <= jdo[33:24].
- take_action_ocimem_a with jdo[35]=1 then issues a read at the (new) addr.
- take_action_ocimem_a with jdo[36]=1 clears monitor_error.
- take_action_ocimem_b writes jdo[34:3] to addr.
- take_no_action_ocimem_a reads addr.
REQ-005 Simultaneous strobes SHALL use priority a > b > no_action_a; a lower-priority strobe is dropped and monitor_error is set.
REQ-006 The FSM SHALL have four states:
- IDLE -> RD_REQ on an accepted read.
- IDLE -> WR_REQ on an accepted write.
- RD_REQ -> RD_WAIT when mem_read is high and mem_waitrequest is low.
- RD_WAIT -> IDLE on mem_readdatavalid or on timeout.
- WR_REQ -> IDLE when mem_write is high and mem_waitrequest is low.
REQ-007 A command accepted at edge N SHALL assert mem_read/mem_write from cycle N+1; the request stays held, with address and data stable, while mem_waitrequest=1.
REQ-008 On mem_readdatavalid, MonDReg SHALL load mem_readdata and monitor_ready SHALL be set on the same edge.
REQ-009 On write completion, monitor_ready SHALL be set on the completing edge; MonDReg is unchanged.
REQ-010 monitor_ready SHALL clear on the edge a read/write command is accepted; an address-only command (jdo[35]=0) leaves it set.
REQ-011 addr SHALL post-increment by 1 after every completed read or write, wrapping (2^ADDR_W-1) -> 0.
REQ-012 Any strobe arriving outside IDLE SHALL be dropped, set monitor_error, and leave the state and addr unchanged.
REQ-013 The timeout counter SHALL start at 0 on entry to RD_WAIT and increment each cycle.
REQ-014 When the counter reaches TIMEOUT without mem_readdatavalid, the block SHALL:
- load MonDReg = 32'hDEAD_DEAD;
- set monitor_error and monitor_ready;
- return to IDLE without incrementing addr.
REQ-015 A mem_readdatavalid arriving outside RD_WAIT SHALL be ignored.
REQ-016 monitor_error SHALL clear only by reset or REQ-004 jdo[36]; a set and a clear on the same edge leave it set.

Reset
REQ-017 Assertion of reset_n=0 SHALL immediately force the following values:
- state IDLE, addr 0, timeout counter 0;
- mem_read 0, mem_write 0, mem_writedata 0, mem_address 0;
- MonDReg 0, monitor_ready 1, monitor_error 0.
REQ-018 Reset mid-transaction SHALL abandon the bus cycle with no further handshake; a late mem_readdatavalid is ignored per REQ-015.
REQ-019 Reset deassertion SHALL be synchronised externally; the block accepts commands from the first edge after release.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, ADDR_W/TIMEOUT defaults, jdo field bit positions (ADDR_HI/LO, RD_BIT, LDADDR_BIT, CLRERR_BIT, WDATA_HI/LO), and the DEAD_DEAD constant.
REQ-021 The timeout counter SHALL be a sub-module `chip_checker_platorm_dbg_mem_timeout` (ports: clk, reset_n, start, tick-enable, expired); all other logic stays in one module.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Address+read: a-strobe with jdo[35:34]=11, jdo[33:24]=0x05, zero-wait slave returning 0x1234_5678 after 2 cycles -> mem_address=5; MonDReg=0x1234_5678; monitor_ready high; addr=6.
- Write with stall: b-strobe, jdo[34:3]=0xCAFE_F00D, waitrequest high 3 cycles -> mem_write held 4 cycles with stable data; monitor_ready rises on release.
- Wrap: addr=0x3FF, no_action read -> after completion addr=0.
- Timeout: read with no readdatavalid for 255 cycles -> MonDReg=0xDEAD_DEAD; monitor_error=1; monitor_ready=1; addr unchanged.
- Busy/simultaneous: b-strobe during RD_WAIT -> dropped, monitor_error=1; then a+b same cycle in IDLE -> only a executed; a-strobe with jdo[36]=1 and no other event -> monitor_error=0.
- Reset mid-read: reset_n low in RD_WAIT -> all outputs at REQ-017 values; a subsequent stale readdatavalid leaves MonDReg=0.
